// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle MIPS mult/div unit owning the HI/LO registers.
// Define MULDIV_MUL2_EN to split the multiplier into two pipeline stages.
module hilo_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [1:0]        mult,
  input  logic [1:0]        div,
  input  logic [1:0]        mfhl,
  input  logic [1:0]        mthl,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              cancel,
  output logic              op_ready,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int W2 = 2 * DATA_W;
  localparam int HW = DATA_W / 2;
  localparam logic [DATA_W-1:0] ZERO = '0;

`ifdef MULDIV_MUL2_EN
  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_MUL2, S_DIV, S_FIX
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_FIX
  } state_t;
`endif

  state_t            r_state;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_sgn;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_q;
  logic              r_neg_r;
`ifdef MULDIV_MUL2_EN
  logic [W2-1:0]     r_pp;
`endif

  logic              w_idle;
  logic              w_acc;
  logic              w_acc_mul;
  logic              w_acc_div;
  logic              w_acc_mt;
  logic              w_rs_neg;
  logic              w_rt_neg;
  logic [DATA_W-1:0] w_rs_abs;
  logic [DATA_W-1:0] w_rt_abs;
  logic              w_rt_zero;
  logic [W2-1:0]     w_a_ext;
  logic [W2-1:0]     w_prod;
  logic [DATA_W:0]   w_trial;
  logic              w_ge;
  logic [DATA_W-1:0] w_rem_nx;
  logic [DATA_W-1:0] w_quo_nx;
  logic [DATA_W-1:0] w_q_fix;
  logic [DATA_W-1:0] w_r_fix;
  logic              w_fin;

  // Acceptance and opcode priority: mult > div > mthl > mfhl
  assign w_idle    = (r_state == S_IDLE);
  assign w_acc     = op_valid & w_idle & ~cancel;
  assign w_acc_mul = w_acc & (|mult);
  assign w_acc_div = w_acc & ~(|mult) & (|div);
  assign w_acc_mt  = w_acc & ~(|mult) & ~(|div) & (|mthl);

  // Divider operand magnitudes and sign flags
  assign w_rs_neg  = div[0] & rs_val[DATA_W-1];
  assign w_rt_neg  = div[0] & rt_val[DATA_W-1];
  assign w_rs_abs  = w_rs_neg ? (ZERO - rs_val) : rs_val;
  assign w_rt_abs  = w_rt_neg ? (ZERO - rt_val) : rt_val;
  assign w_rt_zero = (rt_val == ZERO);

  // Multiplier: operands extended to full product width
  assign w_a_ext = {{DATA_W{r_sgn & r_a[DATA_W-1]}}, r_a};

`ifdef MULDIV_MUL2_EN
  logic [W2-1:0] w_b_lo_ext;
  logic [W2-1:0] w_b_hi_ext;
  logic [W2-1:0] w_pp;
  logic [W2-1:0] w_hi_pp;

  assign w_b_lo_ext = {{(W2-HW){1'b0}}, r_b[HW-1:0]};
  assign w_b_hi_ext = {{(W2-HW){r_sgn & r_b[DATA_W-1]}},
                       r_b[DATA_W-1:HW]};
  assign w_pp       = w_a_ext * w_b_lo_ext;
  assign w_hi_pp    = w_a_ext * w_b_hi_ext;
  assign w_prod     = r_pp + (w_hi_pp << HW);
  assign w_fin      = (r_state == S_MUL2) |
                      (r_state == S_FIX);
`else
  logic [W2-1:0] w_b_ext;

  assign w_b_ext = {{DATA_W{r_sgn & r_b[DATA_W-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_fin   = (r_state == S_MUL) |
                   (r_state == S_FIX);
`endif

  // Restoring division step: one quotient bit per cycle
  assign w_trial  = {r_rem, r_quo[DATA_W-1]} - {1'b0, r_b};
  assign w_ge     = ~w_trial[DATA_W];
  assign w_rem_nx = w_ge ? w_trial[DATA_W-1:0]
                         : {r_rem[DATA_W-2:0], r_quo[DATA_W-1]};
  assign w_quo_nx = {r_quo[DATA_W-2:0], w_ge};

  // Sign fix-up of the unsigned quotient/remainder
  assign w_q_fix = r_neg_q ? (ZERO - r_quo) : r_quo;
  assign w_r_fix = r_neg_r ? (ZERO - r_rem) : r_rem;

  // Control FSM together with HI/LO and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`ifdef MULDIV_MUL2_EN
      r_pp    <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_acc_mul) begin
            r_a     <= rs_val;
            r_b     <= rt_val;
            r_sgn   <= mult[0];
            r_state <= S_MUL;
          end else if (w_acc_div) begin
            r_sgn <= div[0];
            if (w_rt_zero) begin
              r_quo   <= '1;
              r_rem   <= rs_val;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= S_FIX;
            end else begin
              r_quo   <= w_rs_abs;
              r_b     <= w_rt_abs;
              r_rem   <= '0;
              r_neg_q <= w_rs_neg ^ w_rt_neg;
              r_neg_r <= w_rs_neg;
              r_cnt   <= CNT_W'(DATA_W - 1);
              r_state <= S_DIV;
            end
          end else if (w_acc_mt) begin
            if (mthl[0]) r_lo <= rs_val;
            if (mthl[1]) r_hi <= rs_val;
          end
        end
        S_MUL: begin
          if (cancel) begin
            r_state <= S_IDLE;
          end else begin
`ifdef MULDIV_MUL2_EN
            r_pp    <= w_pp;
            r_state <= S_MUL2;
`else
            r_hi    <= w_prod[W2-1:DATA_W];
            r_lo    <= w_prod[DATA_W-1:0];
            r_state <= S_IDLE;
`endif
          end
        end
`ifdef MULDIV_MUL2_EN
        S_MUL2: begin
          if (!cancel) begin
            r_hi <= w_prod[W2-1:DATA_W];
            r_lo <= w_prod[DATA_W-1:0];
          end
          r_state <= S_IDLE;
        end
`endif
        S_DIV: begin
          if (cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            if (r_cnt == '0) begin
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        S_FIX: begin
          if (!cancel) begin
            r_lo <= w_q_fix;
            r_hi <= w_r_fix;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign op_ready = w_idle;
  assign busy     = ~w_idle;
  assign done     = w_fin & ~cancel & ~reset;
  assign rd_data  = mfhl[1] ? r_hi : r_lo;
  assign rd_valid = op_valid & w_idle & (|mfhl);
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
Multi-cycle multiply/divide unit with the architectural HI/LO registers. It executes the eight MIPS mult/div/move-HI/LO instructions that the decoder flags on its MULT, DIV, MFHL and MTHL outputs. It sits beside the ALU in the execute stage and stalls the pipeline through op_ready/busy while an operation is in flight. Width-parametrised and cancellable on pipeline flush.

Parameters:
DATA_W, 32, operand, HI and LO width; must be even and at least 4.
CNT_W, 6, divider iteration counter width; must satisfy 2**CNT_W > DATA_W.

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
op_valid  in  1  decoded instruction valid this cycle
mult  in  2  bit0 = signed MULT, bit1 = MULTU
div  in  2  bit0 = signed DIV, bit1 = DIVU
mfhl  in  2  bit0 = MFLO, bit1 = MFHI
mthl  in  2  bit0 = MTLO, bit1 = MTHI
rs_val  in  DATA_W  operand A / dividend / MT source
rt_val  in  DATA_W  operand B / divisor
cancel  in  1  flush: abort the in-flight operation
op_ready  out  1  unit can accept any op this cycle (state IDLE)
busy  out  1  ~op_ready
rd_data  out  DATA_W  mfhl[1] ? HI : LO, combinational
rd_valid  out  1  op_valid & op_ready & |mfhl
done  out  1  one-cycle pulse in the cycle HI/LO take a mult/div result
hi  out  DATA_W  HI register
lo  out  DATA_W  LO register

Behaviour:
- Reset: state IDLE; hi, lo, internal counter and shift registers cleared to 0. Outputs: op_ready=1, busy=0, done=0, rd_valid=0.
- Accept: an op is accepted on an edge where op_valid & op_ready. Control-bit priority: mult > div > mthl > mfhl. Setting more than one bit is illegal, but the unit must still follow this priority.
- If op_valid is high while busy, the op is not accepted and rd_valid=0. The pipeline must hold the op until op_ready returns.
- MTHI/MTLO: hi (or lo) <= rs_val on the accept edge. No busy cycle, no done pulse.
- MFHI/MFLO: combinational read, valid only when op_ready=1. HI/LO written on edge N are readable in cycle N+1.
- States: IDLE, MUL, DIV, FIX.
- MULT/MULTU: accept edge latches the operands; IDLE->MUL.
  - MUL lasts 1 cycle. At its end {hi,lo} <= 2*DATA_W product, done=1 during MUL, then ->IDLE.
  - Signed: two's-complement operands. Unsigned: zero-extended operands.
- DIV/DIVU: accept edge latches |rs| and |rt| (raw values for DIVU) and the sign flags; counter <= DATA_W-1; IDLE->DIV.
  - DIV runs DATA_W cycles of restoring radix-2 division, one quotient bit per cycle. When counter==0, ->FIX.
  - FIX runs 1 cycle: signed only, negate the quotient if the operand signs differ and give the remainder the dividend's sign. Then lo<=quotient, hi<=remainder, done=1 during FIX, ->IDLE.
  - Total busy = DATA_W+1 cycles.
- Divide by zero: detected at accept; the unit goes directly to FIX (busy 1 cycle). Result: lo = all ones, hi = rs_val, signed or unsigned.
- Signed overflow (min / -1): lo = min, hi = 0, with no exception.
- cancel:
  - In MUL/DIV/FIX: next state is IDLE, hi/lo unchanged, done=0.
  - In IDLE: cancel blocks acceptance that cycle, and an MT op is not written.
- reset during an op takes priority over everything: the op is aborted and hi/lo are cleared.

Optional Feature:
MULDIV_MUL2_EN:
- Defined: the multiplier is split into two pipeline stages. A registered DATA_W x DATA_W/2 partial product is held in a new state MUL2 (sequence MUL->MUL2). Multiply busy becomes 2 cycles, with done in MUL2. cancel in MUL2 aborts the op just like in MUL.
- Undefined: single MUL cycle as above.

Test Plan:
- reset, then MTHI rs=0x12345678 and MTLO rs=0x9ABCDEF0; next cycle MFHI -> rd_data=0x12345678 with rd_valid=1, and MFLO -> 0x9ABCDEF0.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> busy 1 cycle, done=1 once, then hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> busy exactly 33 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=100, rt=7 -> lo=14, hi=2.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU rs=9, rt=0 -> busy 1 cycle, lo=0xFFFFFFFF, hi=9.
- DIVU in flight, hold MFHI op_valid -> rd_valid=0 and op_ready=0 until the cycle after done; then rd_data shows the new hi.
- DIV in flight, pulse cancel at iteration 10 -> IDLE next cycle, no done pulse, hi/lo keep their pre-DIV values. Repeat with reset -> hi=lo=0.
